rectangle_round_ctrl: RTL

- Iterative RECTANGLE encryption controller. Sequences one full round per clock over a 64-bit state register: AddRoundKey, SubColumn, ShiftRow. The ShiftRow step is the existing row-rotation permutation datapath.
- Fetches round keys from an external key-schedule/key-store through an indexed request port that can stall.
- Accepts plaintext and returns ciphertext over valid/ready handshakes.
- Sits between the block I/O wrapper and the key-schedule unit.

---
 rtl/rectangle_round_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rectangle_round_ctrl.sv
// Purpose: iterative RECTANGLE encryption, one full round (AddRoundKey, SubColumn, ShiftRow) per core cycle.
// Latency: ROUNDS+2 edges from plaintext accept to out_valid, plus one edge per cycle rk_valid is low.
// Backpressure: rk_valid low stalls the round in place; out_ready low holds ct/out_valid in DONE and blocks new input.
module rectangle_round_ctrl #(
    parameter int ROUNDS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] pt,
    output logic [4:0]  rk_idx,
    output logic        rk_req,
    input  logic [63:0] rk,
    input  logic        rk_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ct,
    output logic        busy,
    output logic [4:0]  round
);

    localparam logic [4:0] LAST_RND  = 5'(ROUNDS - 1);
    localparam logic [4:0] FINAL_IDX = 5'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    fsm_t        fsm;
    fsm_t        fsm_nxt;
    logic [63:0] state;
    logic [63:0] round_dat;

    // 4-bit RECTANGLE S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Each column is a nibble with row0 as its LSB; substitute all 16 columns in parallel.
    function automatic logic [63:0] sub_column(input logic [63:0] s);
        logic [63:0] r;
        logic [3:0]  y;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            y = sbox({s[48+i], s[32+i], s[16+i], s[i]});
            r[i]    = y[0];
            r[16+i] = y[1];
            r[32+i] = y[2];
            r[48+i] = y[3];
        end
        return r;
    endfunction

    // Row rotation permutation: row1 <<< 1, row2 <<< 12, row3 <<< 13.
    function automatic logic [63:0] shift_row(input logic [63:0] s);
        logic [15:0] r0, r1, r2, r3;
        r0 = s[15:0];
        r1 = {s[30:16], s[31]};
        r2 = {s[35:32], s[47:36]};
        r3 = {s[50:48], s[63:51]};
        return {r3, r2, r1, r0};
    endfunction

    assign round_dat = shift_row(sub_column(state ^ rk));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= S_IDLE;
        else        fsm <= fsm_nxt;
    end

    // Next-state logic: rounds and the whitening step both wait on rk_valid
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE:  if (in_valid) fsm_nxt = S_ROUND;
            S_ROUND: if (rk_valid && (round == LAST_RND)) fsm_nxt = S_FINAL;
            S_FINAL: if (rk_valid) fsm_nxt = S_DONE;
            S_DONE:  if (out_ready) fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // Per-state outputs: key request only while a round or the whitening step is pending
    always_comb begin
        in_ready = 1'b0;
        rk_req   = 1'b0;
        rk_idx   = '0;
        busy     = 1'b0;
        case (fsm)
            S_IDLE:  in_ready = 1'b1;
            S_ROUND: begin
                rk_req = 1'b1;
                rk_idx = round;
                busy   = 1'b1;
            end
            S_FINAL: begin
                rk_req = 1'b1;
                rk_idx = FINAL_IDX;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: cipher state, round counter, ciphertext and its valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= '0;
            round     <= '0;
            ct        <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= pt;
                        round <= '0;
                    end
                end
                S_ROUND: begin
                    if (rk_valid) begin
                        state <= round_dat;
                        if (round != LAST_RND) round <= round + 5'd1;
                    end
                end
                S_FINAL: begin
                    if (rk_valid) begin
                        ct        <= state ^ rk;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
